// File: rtl/cnt_pkg.sv
// Shared constants and types for the cnt8 leaf counter and the blocks that instantiate it.
package cnt_pkg;

  localparam int unsigned CNT_WIDTH = 4;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage : cnt_pkg

// File: rtl/cnt8.sv
// Free-running up-counter with synchronous clear and parallel load; wraps modulo 2^WIDTH.
module cnt8
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pl,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Priority: clear, then load, then increment (natural wrap, no carry-out).
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (pl) begin
      out <= in;
    end else begin
      out <= out + WIDTH'(1);
    end
  end

endmodule : cnt8

// File: tb/tb_cnt8.sv
// Directed bench for cnt8: arithmetic reference model checked every cycle plus literal spot checks.
module tb_cnt8;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned MODULUS = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             pl;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

  int  tests = 0;
  int  fails = 0;
  int  exp_val = 0;
  bit  model_valid = 1'b0;

  cnt8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .pl    (pl),
    .in    (in),
    .out   (out)
  );

  always #5 clk = ~clk;

  // Reference model: value the count must hold after each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      exp_val = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (pl) exp_val = int'(in);
      else    exp_val = (exp_val + 1) % MODULUS;
    end else if (pl) begin
      exp_val = int'(in);
      model_valid = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      tests++;
      if (out !== WIDTH'(exp_val)) begin
        fails++;
        $display("FAIL model_cmp t=%0t out=%0d expected=%0d", $time, out, exp_val);
      end
    end
  end

  task automatic step(input logic r, input logic p, input logic [WIDTH-1:0] v);
    reset = r;
    pl    = p;
    in    = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int want);
    tests++;
    if (out !== WIDTH'(want)) begin
      fails++;
      $display("FAIL %s out=%0d expected=%0d", name, out, want);
    end
  endtask

  initial begin
    reset = 1'b0;
    pl    = 1'b0;
    in    = '0;
    @(negedge clk);

    // Reset clears regardless of in; counting starts at 1.
    step(1'b1, 1'b0, 4'b1010); chk("reset", 0);
    step(1'b0, 1'b0, 4'b1010); chk("release_1", 1);
    step(1'b0, 1'b0, 4'b1010); chk("release_2", 2);
    step(1'b0, 1'b0, 4'b1010); chk("release_3", 3);

    // Free run through the wrap.
    repeat (12) step(1'b0, 1'b0, 4'b0000);
    chk("reach_15", 15);
    step(1'b0, 1'b0, 4'b0000); chk("wrap_0", 0);
    step(1'b0, 1'b0, 4'b0000); chk("wrap_1", 1);

    // Reset mid-count.
    repeat (6) step(1'b0, 1'b0, 4'b0000);
    chk("count_7", 7);
    step(1'b1, 1'b0, 4'b0011); chk("reset_mid", 0);
    step(1'b0, 1'b0, 4'b0011); chk("after_reset_mid", 1);

    // Single-cycle parallel load mid-count, then count through wrap.
    repeat (3) step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b1010); chk("load_10", 10);
    step(1'b0, 1'b0, 4'b1010); chk("load_then_11", 11);
    repeat (4) step(1'b0, 1'b0, 4'b0000);
    chk("load_run_15", 15);
    step(1'b0, 1'b0, 4'b0000); chk("load_run_wrap", 0);

    // Reset beats a simultaneous load.
    step(1'b1, 1'b1, 4'b1010); chk("reset_over_pl", 0);

    // Load held three cycles, then counting resumes.
    step(1'b0, 1'b1, 4'b0101); chk("hold_1", 5);
    step(1'b0, 1'b1, 4'b0101); chk("hold_2", 5);
    step(1'b0, 1'b1, 4'b0101); chk("hold_3", 5);
    step(1'b0, 1'b0, 4'b0101); chk("hold_release", 6);

    // Load of all-ones wraps on the next edge; in ignored while pl is low.
    step(1'b0, 1'b1, 4'b1111); chk("load_15", 15);
    step(1'b0, 1'b0, 4'b0000); chk("load_15_wrap", 0);
    step(1'b0, 1'b0, 4'b1001); chk("in_ignored_1", 1);
    step(1'b0, 1'b0, 4'b0011); chk("in_ignored_2", 2);

    // Loading the value it would have reached anyway.
    step(1'b0, 1'b1, 4'b0011); chk("load_same", 3);
    step(1'b0, 1'b0, 4'b0000); chk("load_same_next", 4);

    // Reset held for several cycles, then released straight into a load.
    step(1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b0000); chk("reset_held", 0);
    step(1'b0, 1'b1, 4'b1100); chk("release_into_load", 12);
    repeat (5) step(1'b0, 1'b0, 4'b0000);
    chk("final_count", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_cnt8

// File: doc/cnt8.md
Name: cnt8

Overview:
- Free-running binary up-counter with synchronous parallel load.
- Increments once per clock and wraps modulo 2^WIDTH.
- Can be cleared by reset or preset to an arbitrary value via the load strobe.
- Used as a general-purpose leaf counter (sequencing, timing, address generation) inside larger datapaths.

Parameters:
- WIDTH, 4, counter/load/output bit width (minimum 1); count range 0 .. 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high clear.
- pl  input  1  parallel-load strobe, active-high, sampled on the rising clk edge.
- in  input  WIDTH  parallel-load value.
- out  output  WIDTH  current count; registered, driven directly from the state flop.

Interface decisions:
- One clock; reset is synchronous and active-high.
- Ports named clk and reset.

Behaviour:
- Single WIDTH-bit state register; out = register value; no combinational path from inputs to out.
- Per rising clk edge, priority order:
  1. reset=1 -> register <= 0 (pl and in ignored).
  2. else pl=1 -> register <= in.
  3. else register <= register + 1, modulo 2^WIDTH (2^WIDTH-1 -> 0; no saturation, no carry-out).
- Reset value of out: all zeros, visible after the first rising edge with reset=1.
- Before the first reset edge, out is X in simulation; no power-on value is guaranteed.
- Latency: one cycle for reset, load and increment.
  - pl sampled at edge N -> out==in after edge N.
  - Counting resumes from in+1 at edge N+1.
- Reset held for multiple cycles: out stays 0.
- First edge after reset deasserts: out becomes 1 (unless pl is high, in which case out becomes in).
- Load of 2^WIDTH-1: next edge wraps out to 0.
- Load of the value the counter would have reached anyway: indistinguishable from a normal count; legal.
- pl held high for multiple cycles: out holds in (reloads every cycle); no count while pl=1.
- in changes while pl=0: no effect.
- Reset asserted mid-count or simultaneously with pl: reset wins; out=0 after that edge.
- No enable input: counter advances every cycle it is neither reset nor loading.

Decomposition:
- Shared package (cnt_pkg): default width constant CNT_WIDTH=4 and typedef cnt_t = logic [CNT_WIDTH-1:0], for reuse by instantiating blocks.
- No sub-module: one always_ff process with a priority if/else chain.
- Optional assertions bound alongside: reset-priority, load-takes-effect, increment-modulo properties.

Test Plan (WIDTH=4, 10 ns clock):
- Reset: reset=1 for 1 cycle, pl=0, in=4'b1010 -> out=0. Release reset -> out=1,2,3,... one increment per edge.
- Wrap: free-run 16+ cycles from 0 -> out reaches 15, then 0 on the next edge, then 1; no glitch or stall.
- Parallel load mid-count: after ~20 counts, pl=1 for exactly 1 cycle with in=4'b1010 -> out=10 after that edge, then 11,12,13,14,15,0,1...
- Reset mid-count: while counting (e.g. out=7), reset=1 for 1 cycle -> out=0 after that edge, then 1,2,... after release.
- Priority and hold:
  - reset=1 and pl=1 on the same edge with in=4'b1010 -> out=0.
  - pl=1 held 3 cycles with in=4'b0101 -> out stays 5, then 6 after pl drops.
- Load at boundary: pl=1, in=4'b1111 -> out=15, then 0 on the next edge. Changing in while pl=0 -> no change in count sequence.
